// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM state encoding and sizing helper for alu_seq
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOR = 4'h6;
    localparam logic [3:0] OP_SLL = 4'h7;
    localparam logic [3:0] OP_SRL = 4'h8;
    localparam logic [3:0] OP_SRA = 4'h9;
    localparam logic [3:0] OP_ROL = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_EQ  = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// rtl/alu_seq_comb.sv - combinational datapath for all single-cycle opcodes
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       i_ctrl,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_out,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, i_x} + {1'b0, i_y};
    // The extra top bit of the difference is the borrow out (x < y).
    assign w_diff = {1'b0, i_x} - {1'b0, i_y};

    always_comb begin
        o_out   = '0;
        o_carry = 1'b0;
        case (i_ctrl)
            OP_ADD: {o_carry, o_out} = w_sum;
            OP_SUB: begin
                o_out   = w_diff[WIDTH-1:0];
                o_carry = w_diff[WIDTH];
            end
            OP_AND: o_out = i_x & i_y;
            OP_OR:  o_out = i_x | i_y;
            OP_NOT: o_out = ~i_x;
            OP_XOR: o_out = i_x ^ i_y;
            OP_NOR: o_out = ~(i_x | i_y);
            OP_SLL: o_out = {i_x[WIDTH-2:0], 1'b0};
            OP_SRL: o_out = {1'b0, i_x[WIDTH-1:1]};
            OP_SRA: o_out = {i_x[WIDTH-1], i_x[WIDTH-1:1]};
            OP_ROL: o_out = {i_x[WIDTH-2:0], i_x[WIDTH-1]};
            OP_ROR: o_out = {i_x[0], i_x[WIDTH-1:1]};
            OP_EQ:  o_out = {{(WIDTH-1){1'b0}}, (i_x == i_y)};
            default: begin
                o_out   = '0;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with registered result and shift-add multiply
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             carry,
    output logic [WIDTH-1:0] out
);

    localparam int CW = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   w_comb_out;
    logic               r_carry;
    logic               w_comb_carry;
    logic               w_accept;
    logic               w_mul_last;

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .i_ctrl  (ctrl),
        .i_x     (x),
        .i_y     (y),
        .o_out   (w_comb_out),
        .o_carry (w_comb_carry)
    );

    assign in_ready   = (r_state == ST_IDLE) && !Rst;
    assign out_valid  = (r_state == ST_DONE);
    assign out        = r_out;
    assign carry      = r_carry;
    assign w_accept   = in_valid && in_ready;
    assign w_mul_last = (r_cnt == CW'(WIDTH - 1));
    // Multiplicand shifts left and multiplier right, so bit 0 is always the current bit.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (ctrl == OP_MUL) ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (w_mul_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_out    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (ctrl == OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, x};
                            r_mplier <= y;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                        end else begin
                            r_out   <= w_comb_out;
                            r_carry <= w_comb_carry;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_mul_last) begin
                        r_out   <= w_acc_next[WIDTH-1:0];
                        r_carry <= |w_acc_next[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH 8 and 16
module tb_alu_seq;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid, out_ready;
    logic [3:0]  ctrl;
    logic [7:0]  x, y;
    logic        in_ready, out_valid, carry;
    logic [7:0]  out;

    logic        in_valid16, out_ready16;
    logic [3:0]  ctrl16;
    logic [15:0] x16, y16;
    logic        in_ready16, out_valid16, carry16;
    logic [15:0] out16;

    always #5 Clk = ~Clk;

    alu_seq #(.WIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .carry(carry), .out(out)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .ctrl(ctrl16), .x(x16), .y(y16), .out_valid(out_valid16), .out_ready(out_ready16),
        .carry(carry16), .out(out16)
    );

    typedef struct {
        string      name;
        logic [3:0] c;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] eo;
        logic       ec;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] o;
        logic       c;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input string n, input logic [3:0] c, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] eo, input logic ec);
        vec_t v;
        v.name = n; v.c = c; v.a = a; v.b = b; v.eo = eo; v.ec = ec;
        return v;
    endfunction

    function automatic logic [8:0] model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (c)
            4'h0: return 9'(a) + 9'(b);
            4'h1: return {(a < b), 8'(a - b)};
            4'h2: return {1'b0, a & b};
            4'h3: return {1'b0, a | b};
            4'h4: return {1'b0, ~a};
            4'h5: return {1'b0, a ^ b};
            4'h6: return {1'b0, ~(a | b)};
            4'h7: return {1'b0, 8'(a * 2)};
            4'h8: return {1'b0, a / 2};
            4'h9: return {1'b0, a[7], a[7:1]};
            4'hA: return {1'b0, a[6:0], a[7]};
            4'hB: return {1'b0, a[0], a[7:1]};
            4'hC: return (a == b) ? 9'h001 : 9'h000;
            4'hD: return {(p[15:8] != 8'h00), p[7:0]};
            default: return 9'h000;
        endcase
    endfunction

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected result", 16'd1, 16'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, " out"}, 16'(out), 16'(e.o));
                chk({e.name, " carry"}, 16'(carry), 16'(e.c));
            end
        end
    end

    task automatic do_op(input string name, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eo, input logic ec);
        int lat;
        exp_t e;
        chk({name, " in_ready"}, 16'(in_ready), 16'd1);
        in_valid = 1'b1; ctrl = c; x = a; y = b;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        ctrl = 4'($urandom); x = 8'($urandom); y = 8'($urandom);
        e.name = name; e.o = eo; e.c = ec;
        sb.push_back(e);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge Clk); #1;
            lat++;
        end
        chk({name, " latency"}, 16'(lat), (c == 4'hD) ? 16'd8 : 16'd0);
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        chk({name, " out_valid drop"}, 16'(out_valid), 16'd0);
    endtask

    task automatic op16(input string name, input logic [3:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] eo, input logic ec, input int elat);
        int lat;
        chk({name, " in_ready"}, 16'(in_ready16), 16'd1);
        in_valid16 = 1'b1; ctrl16 = c; x16 = a; y16 = b;
        @(posedge Clk); #1;
        in_valid16 = 1'b0; x16 = 16'($urandom); y16 = 16'($urandom);
        lat = 0;
        while (!out_valid16 && lat < 64) begin
            @(posedge Clk); #1;
            lat++;
        end
        chk({name, " latency"}, 16'(lat), 16'(elat));
        chk({name, " out"}, out16, eo);
        chk({name, " carry"}, 16'(carry16), 16'(ec));
        @(posedge Clk); #1;
        chk({name, " consumed"}, 16'(out_valid16), 16'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: time limit reached, checks so far %0d", n_checks);
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] held_o;
        logic       held_c;
        logic [8:0] m;
        logic [3:0] rc;
        logic [7:0] ra, rb;
        int         lat;
        int         seen;

        vecs.push_back(mk("ADD FF+01", 4'h0, 8'hFF, 8'h01, 8'h00, 1'b1));
        vecs.push_back(mk("SUB 00-01", 4'h1, 8'h00, 8'h01, 8'hFF, 1'b1));
        vecs.push_back(mk("ADD 05 03", 4'h0, 8'h05, 8'h03, 8'h08, 1'b0));
        vecs.push_back(mk("SUB 05 03", 4'h1, 8'h05, 8'h03, 8'h02, 1'b0));
        vecs.push_back(mk("AND 05 03", 4'h2, 8'h05, 8'h03, 8'h01, 1'b0));
        vecs.push_back(mk("OR 05 03",  4'h3, 8'h05, 8'h03, 8'h07, 1'b0));
        vecs.push_back(mk("NOT 05",    4'h4, 8'h05, 8'h03, 8'hFA, 1'b0));
        vecs.push_back(mk("XOR 05 03", 4'h5, 8'h05, 8'h03, 8'h06, 1'b0));
        vecs.push_back(mk("NOR 05 03", 4'h6, 8'h05, 8'h03, 8'hF8, 1'b0));
        vecs.push_back(mk("SLL 05",    4'h7, 8'h05, 8'h03, 8'h0A, 1'b0));
        vecs.push_back(mk("SRL 05",    4'h8, 8'h05, 8'h03, 8'h02, 1'b0));
        vecs.push_back(mk("SRA 05",    4'h9, 8'h05, 8'h03, 8'h02, 1'b0));
        vecs.push_back(mk("ROL 05",    4'hA, 8'h05, 8'h03, 8'h0A, 1'b0));
        vecs.push_back(mk("ROR 05",    4'hB, 8'h05, 8'h03, 8'h82, 1'b0));
        vecs.push_back(mk("EQ 05 03",  4'hC, 8'h05, 8'h03, 8'h00, 1'b0));
        vecs.push_back(mk("EQ FF FF",  4'hC, 8'hFF, 8'hFF, 8'h01, 1'b0));
        vecs.push_back(mk("SLL 01",    4'h7, 8'h01, 8'h00, 8'h02, 1'b0));
        vecs.push_back(mk("ROR 01",    4'hB, 8'h01, 8'h00, 8'h80, 1'b0));
        vecs.push_back(mk("SRL 01",    4'h8, 8'h01, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk("SLL 80",    4'h7, 8'h80, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk("SRA 80",    4'h9, 8'h80, 8'h00, 8'hC0, 1'b0));
        vecs.push_back(mk("ROL 80",    4'hA, 8'h80, 8'h00, 8'h01, 1'b0));
        vecs.push_back(mk("SRL 80",    4'h8, 8'h80, 8'h00, 8'h40, 1'b0));
        vecs.push_back(mk("ROL C0",    4'hA, 8'hC0, 8'h00, 8'h81, 1'b0));
        vecs.push_back(mk("SRA C0",    4'h9, 8'hC0, 8'h00, 8'hE0, 1'b0));
        vecs.push_back(mk("SLL C0",    4'h7, 8'hC0, 8'h00, 8'h80, 1'b0));
        vecs.push_back(mk("ROR 81",    4'hB, 8'h81, 8'h00, 8'hC0, 1'b0));
        vecs.push_back(mk("ROL 81",    4'hA, 8'h81, 8'h00, 8'h03, 1'b0));
        vecs.push_back(mk("SRL 81",    4'h8, 8'h81, 8'h00, 8'h40, 1'b0));
        vecs.push_back(mk("MUL 0F*11", 4'hD, 8'h0F, 8'h11, 8'hFF, 1'b0));
        vecs.push_back(mk("MUL 10*10", 4'hD, 8'h10, 8'h10, 8'h00, 1'b1));
        vecs.push_back(mk("MUL FF*FF", 4'hD, 8'hFF, 8'hFF, 8'h01, 1'b1));
        vecs.push_back(mk("ILL E",     4'hE, 8'hFF, 8'hFF, 8'h00, 1'b0));
        vecs.push_back(mk("ILL F",     4'hF, 8'h12, 8'h34, 8'h00, 1'b0));

        Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ctrl = '0; x = '0; y = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; ctrl16 = '0; x16 = '0; y16 = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset out_valid", 16'(out_valid), 16'd0);
        chk("reset out", 16'(out), 16'd0);
        chk("reset carry", 16'(carry), 16'd0);
        chk("reset in_ready", 16'(in_ready), 16'd0);
        chk("reset out_valid16", 16'(out_valid16), 16'd0);
        Rst = 1'b0;
        #1;

        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].ec);
        end

        for (int i = 0; i < 10; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            rb = 8'($urandom);
            m  = model(rc, ra, rb);
            do_op($sformatf("rand op%0h %h %h", rc, ra, rb), rc, ra, rb, m[7:0], m[8]);
        end

        // Backpressure: result held, no second accept while DONE
        chk("bp in_ready", 16'(in_ready), 16'd1);
        in_valid = 1'b1; ctrl = 4'h0; x = 8'h05; y = 8'h03;
        @(posedge Clk); #1;
        sb.push_back('{name: "bp ADD 05 03", o: 8'h08, c: 1'b0});
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge Clk); #1;
            lat++;
        end
        chk("bp latency", 16'(lat), 16'd0);
        held_o = out; held_c = carry;
        in_valid = 1'b1; ctrl = 4'h0; x = 8'hFF; y = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            @(posedge Clk); #1;
            chk("bp out stable", 16'(out), 16'(held_o));
            chk("bp carry stable", 16'(carry), 16'(held_c));
            chk("bp in_ready low", 16'(in_ready), 16'd0);
            chk("bp out_valid held", 16'(out_valid), 16'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) seen++;
            @(posedge Clk); #1;
        end
        chk("bp no extra result", 16'(seen), 16'd0);

        // Reset in the middle of a multiply discards it
        chk("rst-mul in_ready", 16'(in_ready), 16'd1);
        in_valid = 1'b1; ctrl = 4'hD; x = 8'hFF; y = 8'hFF;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        Rst = 1'b1;
        #1;
        chk("in_ready during Rst", 16'(in_ready), 16'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        #1;
        chk("rst-mul out_valid", 16'(out_valid), 16'd0);
        chk("rst-mul out", 16'(out), 16'd0);
        chk("rst-mul carry", 16'(carry), 16'd0);
        chk("rst-mul idle", 16'(in_ready), 16'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge Clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("rst-mul no result", 16'(seen), 16'd0);
        do_op("ADD 01+01 after rst", 4'h0, 8'h01, 8'h01, 8'h02, 1'b0);

        // WIDTH = 16
        out_ready16 = 1'b1;
        op16("w16 ADD FFFF+0001", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0);
        op16("w16 MUL 0100*0100", 4'hD, 16'h0100, 16'h0100, 16'h0000, 1'b1, 16);
        op16("w16 MUL 00FF*0101", 4'hD, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 16);
        op16("w16 SRA 8000",      4'h9, 16'h8000, 16'h0000, 16'hC000, 1'b0, 0);

        chk("scoreboard drained", 16'(sb.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
